// File: rtl/parking_ledger_pkg.sv
// Shared types and helpers for the parking ledger: FSM state encoding,
// default widths, slot-ID width and fee saturation.
package parking_pkg;

   localparam int unsigned TIME_W_DEF = 11;
   localparam int unsigned FEE_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_e;

   // Width needed to carry slot IDs 0..n.
   function automatic int unsigned slot_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // Clamp a product to the largest value representable in fw bits.
   function automatic logic [63:0] sat_fee(input logic [63:0] prod, input int unsigned fw);
      logic [63:0] lim;
      if (fw >= 64) return prod;
      lim = (64'd1 << fw) - 64'd1;
      return (prod > lim) ? lim : prod;
   endfunction

endpackage

// File: rtl/parking_ledger_if.sv
// Request/response and status bundle between the keypad front end
// (master) and the parking ledger (slave).
interface parking_ledger_if
   import parking_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 6,
   parameter int unsigned TIME_W    = TIME_W_DEF,
   parameter int unsigned FEE_W     = FEE_W_DEF
) ();

   localparam int unsigned SLOT_W = slot_w(NUM_SLOTS);

   logic                 req_valid;
   logic                 req_ready;
   logic [SLOT_W-1:0]    req_slot;
   logic [TIME_W-1:0]    timer;
   logic                 resp_valid;
   logic                 resp_checkout;
   logic                 resp_error;
   logic [FEE_W-1:0]     resp_fee;
   logic [NUM_SLOTS-1:0] occupied;
   logic [SLOT_W-1:0]    free_count;

   modport master (
      output req_valid, req_slot, timer,
      input  req_ready, resp_valid, resp_checkout, resp_error, resp_fee,
             occupied, free_count
   );

   modport slave (
      input  req_valid, req_slot, timer,
      output req_ready, resp_valid, resp_checkout, resp_error, resp_fee,
             occupied, free_count
   );

endinterface

// File: rtl/parking_ledger_fee_calc.sv
// Combinational fee: elapsed ticks (less the grace period when
// PARKING_GRACE_EN is defined) times RATE, saturated to FEE_W bits.
module parking_fee_calc
   import parking_pkg::*;
#(
   parameter int unsigned TIME_W = TIME_W_DEF,
   parameter int unsigned FEE_W  = FEE_W_DEF,
   parameter int unsigned RATE   = 1,
   parameter int unsigned GRACE  = 5
) (
   input  logic [TIME_W-1:0] elapsed_i,
   output logic [FEE_W-1:0]  fee_o
);

   localparam int unsigned PROD_W = TIME_W + $clog2(RATE + 1);

   logic [TIME_W-1:0] charged;
   logic [PROD_W-1:0] prod;

   // Charged ticks, full-width product, then clamp.
   always_comb begin
`ifdef PARKING_GRACE_EN
      if (elapsed_i < TIME_W'(GRACE)) charged = '0;
      else                            charged = elapsed_i - TIME_W'(GRACE);
`else
      charged = elapsed_i;
`endif
      prod  = PROD_W'(charged) * PROD_W'(RATE);
      fee_o = FEE_W'(sat_fee(64'(prod), FEE_W));
   end

endmodule

// File: rtl/parking_ledger.sv
// Parking ledger top: check-in/check-out per bay with entry-time storage,
// three-cycle IDLE/EXEC/RESP transaction, occupancy map and free count.
// Optional grace period is enabled with the PARKING_GRACE_EN macro.
module parking_ledger
   import parking_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 6,
   parameter int unsigned TIME_W    = TIME_W_DEF,
   parameter int unsigned FEE_W     = FEE_W_DEF,
   parameter int unsigned RATE      = 1,
   parameter int unsigned GRACE     = 5
) (
   input  logic            clk,
   input  logic            reset,
   parking_ledger_if.slave bus
);

   localparam int unsigned SLOT_W = slot_w(NUM_SLOTS);

   state_e               state_q, state_d;
   logic [SLOT_W-1:0]    slot_q;
   logic [TIME_W-1:0]    time_q;
   logic [TIME_W-1:0]    entry_q [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] occ_q;
   logic [SLOT_W-1:0]    free_q;
   logic                 chk_q, err_q;
   logic [FEE_W-1:0]     fee_q;

   logic [NUM_SLOTS-1:0] hit;
   logic                 hit_occ;
   logic [TIME_W-1:0]    entry_sel;
   logic [TIME_W-1:0]    elapsed;
   logic [FEE_W-1:0]     fee_calc;

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next state: accept only in IDLE, then a fixed EXEC/RESP pair
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.req_valid) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus.req_ready  = (state_q == IDLE);
      bus.resp_valid = (state_q == RESP);
   end

   assign bus.resp_checkout = chk_q;
   assign bus.resp_error    = err_q;
   assign bus.resp_fee      = fee_q;
   assign bus.occupied      = occ_q;
   assign bus.free_count    = free_q;

   // Slot decode: one-hot hit (all-zero for out-of-range IDs) and elapsed time
   always_comb begin
      hit       = '0;
      hit_occ   = 1'b0;
      entry_sel = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (slot_q == SLOT_W'(i + 1)) begin
            hit[i]    = 1'b1;
            hit_occ   = occ_q[i];
            entry_sel = entry_q[i];
         end
      end
      elapsed = time_q - entry_sel;
   end

   parking_fee_calc #(
      .TIME_W (TIME_W),
      .FEE_W  (FEE_W),
      .RATE   (RATE),
      .GRACE  (GRACE)
   ) u_fee (
      .elapsed_i (elapsed),
      .fee_o     (fee_calc)
   );

   // Request register: capture slot and time on acceptance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q <= '0;
         time_q <= '0;
      end else if (state_q == IDLE && bus.req_valid) begin
         slot_q <= bus.req_slot;
         time_q <= bus.timer;
      end
   end

   // Ledger and response registers, updated in the EXEC cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) entry_q[i] <= '0;
         occ_q  <= '0;
         free_q <= SLOT_W'(NUM_SLOTS);
         chk_q  <= 1'b0;
         err_q  <= 1'b0;
         fee_q  <= '0;
      end else if (state_q == EXEC) begin
         if (hit == '0) begin
            err_q <= 1'b1;
            chk_q <= 1'b0;
            fee_q <= '0;
         end else if (hit_occ) begin
            err_q  <= 1'b0;
            chk_q  <= 1'b1;
            fee_q  <= fee_calc;
            occ_q  <= occ_q & ~hit;
            free_q <= free_q + SLOT_W'(1);
            for (int unsigned i = 0; i < NUM_SLOTS; i++)
               if (hit[i]) entry_q[i] <= '0;
         end else begin
            err_q  <= 1'b0;
            chk_q  <= 1'b0;
            fee_q  <= '0;
            occ_q  <= occ_q | hit;
            free_q <= free_q - SLOT_W'(1);
            for (int unsigned i = 0; i < NUM_SLOTS; i++)
               if (hit[i]) entry_q[i] <= time_q;
         end
      end
   end

endmodule
